// File: rtl/sum_par_pkg.sv
// Shared types and elaboration helpers for the multi-lane burst accumulator.
package sum_par_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    REDUCE  = 2'd2,
    DONE    = 2'd3
  } state_e;

  function automatic int lane_w(input int data_w, input int lanes, input int samples);
    return data_w + $clog2(samples / lanes);
  endfunction

  function automatic int sum_w(input int data_w, input int samples);
    return data_w + $clog2(samples);
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit params_ok(input int lanes, input int samples);
    return is_pow2(lanes) && (lanes >= 2) && is_pow2(samples) &&
           (samples >= lanes) && ((samples % lanes) == 0);
  endfunction

endpackage

// File: rtl/sum_par_lane.sv
// One lane accumulator: synchronous clear wins over a qualified add.
module sum_par_lane
  import sum_par_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LANE_W = lane_w(8, 4, 128)
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [LANE_W-1:0] acc
);

  logic [LANE_W-1:0] acc_q;
  logic [LANE_W-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + LANE_W'(din);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/sum_parallel_param.sv
// Burst accumulator: samples dealt round-robin over LANES accumulators, then reduced.
// Define SUM_PAR_AVG_EN to report the rounded mean instead of the raw total.
module sum_parallel_param
  import sum_par_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int LANES   = 4,
  parameter int SAMPLES = 128
) (
  input  logic                                  CLK,
  input  logic                                  RST_n,
  input  logic                                  data_start,
  input  logic                                  in_valid,
  input  logic [DATA_W-1:0]                     input_data,
  output logic                                  busy,
  output logic [sum_w(DATA_W, SAMPLES)-1:0]     sum,
  output logic                                  sum_enable,
  output logic                                  overrun
);

  localparam int LANE_W = lane_w(DATA_W, LANES, SAMPLES);
  localparam int SUM_W  = sum_w(DATA_W, SAMPLES);
  localparam int CNT_W  = $clog2(SAMPLES) + 1;
  localparam int SEL_W  = $clog2(LANES);
  localparam int LOG_S  = $clog2(SAMPLES);

  if (!params_ok(LANES, SAMPLES)) begin : g_bad_params
    $error("sum_parallel_param: LANES and SAMPLES must be powers of two, LANES >= 2, SAMPLES a multiple of LANES");
  end

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic              sum_enable_q, sum_enable_d;
  logic              overrun_q, overrun_d;

  logic              lane_clr;
  logic              lane_add;
  logic [LANE_W-1:0] lane_acc [LANES];
  logic [SUM_W-1:0]  total;
  logic [SUM_W-1:0]  result;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    sum_par_lane #(
      .DATA_W (DATA_W),
      .LANE_W (LANE_W)
    ) u_lane (
      .CLK   (CLK),
      .RST_n (RST_n),
      .clr   (lane_clr),
      .en    (lane_add && (cnt_q[SEL_W-1:0] == SEL_W'(gi))),
      .din   (input_data),
      .acc   (lane_acc[gi])
    );
  end

  always_comb begin
    total = '0;
    for (int i = 0; i < LANES; i++) begin
      total = total + SUM_W'(lane_acc[i]);
    end
  end

  // Adding SAMPLES/2 cannot carry out of SUM_W: the total is at most (2^DATA_W-1)*SAMPLES.
`ifdef SUM_PAR_AVG_EN
  assign result = (total + SUM_W'(SAMPLES / 2)) >> LOG_S;
`else
  assign result = total;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sum_d        = sum_q;
    sum_enable_d = 1'b0;
    overrun_d    = 1'b0;
    lane_clr     = 1'b0;
    lane_add     = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_start) begin
          state_d  = COLLECT;
          cnt_d    = '0;
          lane_clr = 1'b1;
        end
      end
      COLLECT: begin
        overrun_d = data_start;
        if (in_valid) begin
          lane_add = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(SAMPLES - 1)) begin
            state_d = REDUCE;
          end
        end
      end
      REDUCE: begin
        overrun_d    = data_start;
        sum_d        = result;
        sum_enable_d = 1'b1;
        state_d      = DONE;
      end
      DONE: begin
        // A start here chains straight into the next burst.
        if (data_start) begin
          state_d  = COLLECT;
          cnt_d    = '0;
          lane_clr = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sum_q        <= '0;
      sum_enable_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sum_q        <= sum_d;
      sum_enable_q <= sum_enable_d;
      overrun_q    <= overrun_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign sum        = sum_q;
  assign sum_enable = sum_enable_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_sum_parallel_param.sv
// Directed bench with an expected-result queue; covers the default and an 8-lane/64-sample/12-bit build.
`timescale 1ns/1ps
module tb_sum_parallel_param;

  localparam int A_DW = 8;
  localparam int A_L  = 4;
  localparam int A_S  = 128;
  localparam int A_SW = A_DW + $clog2(A_S);
  localparam int B_DW = 12;
  localparam int B_L  = 8;
  localparam int B_S  = 64;
  localparam int B_SW = B_DW + $clog2(B_S);

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST_n;

  logic            a_start, a_valid;
  logic [A_DW-1:0] a_data;
  logic            a_busy, a_sen, a_ovr;
  logic [A_SW-1:0] a_sum;

  logic            b_start, b_valid;
  logic [B_DW-1:0] b_data;
  logic            b_busy, b_sen, b_ovr;
  logic [B_SW-1:0] b_sum;

  sum_parallel_param #(.DATA_W(A_DW), .LANES(A_L), .SAMPLES(A_S)) dut_a (
    .CLK(CLK), .RST_n(RST_n), .data_start(a_start), .in_valid(a_valid),
    .input_data(a_data), .busy(a_busy), .sum(a_sum), .sum_enable(a_sen), .overrun(a_ovr)
  );

  sum_parallel_param #(.DATA_W(B_DW), .LANES(B_L), .SAMPLES(B_S)) dut_b (
    .CLK(CLK), .RST_n(RST_n), .data_start(b_start), .in_valid(b_valid),
    .input_data(b_data), .busy(b_busy), .sum(b_sum), .sum_enable(b_sen), .overrun(b_ovr)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Expected reported value for a burst whose raw total is 'total'.
  function automatic logic [63:0] model(input longint total, input int samples);
`ifdef SUM_PAR_AVG_EN
    return 64'((total + samples / 2) / samples);
`else
    return 64'(total);
`endif
  endfunction

  function automatic logic [A_DW-1:0] a_val(input int kind, input int i);
    case (kind)
      0:       return 8'hFF;
      1:       return 8'(i);
      2:       return 8'h01;
      default: return 8'h02;
    endcase
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // The sample offered alongside data_start must not be counted.
  task automatic a_begin(input bit push, input longint total);
    if (push) exp_q.push_back(model(total, A_S));
    a_start = 1'b1;
    a_valid = 1'b1;
    a_data  = 8'h55;
    step();
    a_start = 1'b0;
    a_valid = 1'b0;
  endtask

  task automatic a_feed(input int kind, input bit gaps, input int repulse_at, input int stop_at);
    int i;
    int c;
    int pulsed;
    i = 0;
    c = 0;
    pulsed = 0;
    while (i < stop_at) begin
      if (gaps && (c % 3 == 2)) begin
        a_valid = 1'b0;
        a_data  = 8'($urandom_range(0, 255));
      end else begin
        a_valid = 1'b1;
        a_data  = a_val(kind, i);
        if (i == repulse_at) begin
          a_start = 1'b1;
          pulsed  = 1;
        end
        i++;
      end
      c++;
      step();
      a_start = 1'b0;
      if (pulsed == 1) begin
        check("overrun_pulse", a_ovr, 1);
        pulsed = 2;
      end else if (pulsed == 2) begin
        check("overrun_single", a_ovr, 0);
        pulsed = 3;
      end
    end
    a_valid = 1'b0;
  endtask

  // Leaves the bench in the cycle where sum_enable is high.
  task automatic a_wait(output int lat);
    lat = 0;
    while (a_sen !== 1'b1 && lat < 400) begin
      step();
      lat++;
    end
    check("a_sum_enable_seen", a_sen, 1);
    if (a_sen === 1'b1 && exp_q.size() > 0) begin
      check("a_sum", a_sum, exp_q.pop_front());
      $display("burst A: sum=%0d after %0d wait cycles", a_sum, lat);
    end
  endtask

  task automatic b_wait();
    int lat;
    lat = 0;
    while (b_sen !== 1'b1 && lat < 300) begin
      step();
      lat++;
    end
    check("b_sum_enable_seen", b_sen, 1);
    if (b_sen === 1'b1 && exp_q.size() > 0) begin
      check("b_sum", b_sum, exp_q.pop_front());
      $display("burst B: sum=%0d after %0d wait cycles", b_sum, lat);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int pulses;
    longint btot;
    logic [A_SW-1:0] held;

    RST_n = 1'b0;
    a_start = 1'b0; a_valid = 1'b0; a_data = '0;
    b_start = 1'b0; b_valid = 1'b0; b_data = '0;
    repeat (3) step();
    check("rst_busy", a_busy, 0);
    check("rst_sum", a_sum, 0);
    check("rst_sum_enable", a_sen, 0);
    check("rst_overrun", a_ovr, 0);
    check("rst_b_sum", b_sum, 0);
    RST_n = 1'b1;
    step();

    // 128 x 0xFF continuous: data_start..sum_enable spans SAMPLES+3 cycles inclusive.
    a_begin(1, 128 * 255);
    check("busy_after_start", a_busy, 1);
    a_feed(0, 0, -1, A_S);
    a_wait(lat);
    check("start_to_sum_enable_edges", A_S + lat, A_S + 1);
    held = a_sum;
    step();
    check("sum_enable_one_cycle", a_sen, 0);
    check("busy_drop", a_busy, 0);
    check("sum_held", a_sum, held);

    // Ramp with every third cycle idle.
    a_begin(1, 8128);
    a_feed(1, 1, -1, A_S);
    a_wait(lat);
    step();

    // Ramp with data_start re-pulsed at sample 50.
    a_begin(1, 8128);
    a_feed(1, 0, 50, A_S);
    a_wait(lat);
    step();

    // Reset for one cycle at sample 60 aborts the burst.
    a_begin(0, 0);
    a_feed(2, 0, -1, 60);
    RST_n = 1'b0;
    step();
    RST_n = 1'b1;
    check("abort_busy", a_busy, 0);
    check("abort_sum", a_sum, 0);
    check("abort_sum_enable", a_sen, 0);
    check("abort_overrun", a_ovr, 0);
    pulses = 0;
    for (int k = 0; k < 150; k++) begin
      step();
      if (a_sen === 1'b1) pulses++;
    end
    check("abort_no_sum_enable", pulses, 0);
    a_begin(1, 128);
    a_feed(2, 0, -1, A_S);
    a_wait(lat);
    step();

    // Restart accepted in DONE: back-to-back bursts.
    a_begin(1, 128 * 255);
    a_feed(0, 0, -1, A_S);
    a_wait(lat);
    exp_q.push_back(model(256, A_S));
    a_start = 1'b1;
    a_valid = 1'b1;
    a_data  = 8'h77;
    step();
    a_start = 1'b0;
    a_valid = 1'b0;
    check("b2b_busy_no_gap", a_busy, 1);
    check("b2b_sum_enable_one_cycle", a_sen, 0);
    a_feed(3, 0, -1, A_S);
    a_wait(lat);
    step();

    // 8-lane / 64-sample / 12-bit build: all 0xFFF, then random values with random gaps.
    exp_q.push_back(model(64 * 4095, B_S));
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    for (int k = 0; k < B_S; k++) begin
      b_valid = 1'b1;
      b_data  = 12'hFFF;
      step();
    end
    b_valid = 1'b0;
    b_wait();
    step();

    btot = 0;
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    for (int k = 0; k < B_S; k++) begin
      while ($urandom_range(0, 3) == 0) begin
        b_valid = 1'b0;
        b_data  = 12'($urandom_range(0, 4095));
        step();
      end
      b_valid = 1'b1;
      b_data  = 12'($urandom_range(0, 4095));
      btot += longint'(b_data);
      if (k == B_S - 1) exp_q.push_back(model(btot, B_S));
      step();
    end
    b_valid = 1'b0;
    b_wait();
    step();
    check("b_busy_drop", b_busy, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
